// File: rtl/mem_read_adapter_if.sv
// Client/memory signal bundle for mem_read_adapter.
// The adapter takes the slave view; whatever drives it (client and memory side) takes master.
interface mem_read_adapter_if;
  logic        io_enable;
  logic        io_flush;
  logic        io_in_rd;
  logic [16:0] io_in_addr;
  logic        io_in_wait_n;
  logic        io_in_valid;
  logic [31:0] io_in_dout;
  logic        io_out_rd;
  logic [31:0] io_out_addr;
  logic        io_out_wait_n;
  logic        io_out_valid;
  logic [63:0] io_out_dout;

  modport slave (
    input  io_enable, io_flush, io_in_rd, io_in_addr,
    input  io_out_wait_n, io_out_valid, io_out_dout,
    output io_in_wait_n, io_in_valid, io_in_dout,
    output io_out_rd, io_out_addr
  );

  modport master (
    output io_enable, io_flush, io_in_rd, io_in_addr,
    output io_out_wait_n, io_out_valid, io_out_dout,
    input  io_in_wait_n, io_in_valid, io_in_dout,
    input  io_out_rd, io_out_addr
  );
endinterface

// File: rtl/mem_read_adapter.sv
// 32-bit client reads served from 64-bit memory through a one-line cache.
// state | meaning
// IDLE  | accepting requests; hits answered from the cached line
// READ  | io_out_rd held until memory accepts it
// WAIT  | waiting for io_out_valid to fill the line
module mem_read_adapter (
  input logic clock,
  input logic reset,
  mem_read_adapter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        hit;
  logic [16:0] addr_q;
  logic [15:0] tag;
  logic [63:0] data;
  logic        valid;
  logic        in_valid_q;
  logic [31:0] in_dout_q;
  logic [31:0] out_addr_q;

  assign bus.io_in_wait_n = bus.io_enable && (state == IDLE);
  assign accept           = bus.io_in_rd && bus.io_in_wait_n;
  assign hit              = valid && (tag == bus.io_in_addr[16:1]) && !bus.io_flush;
  assign bus.io_out_rd    = (state == READ);
  assign bus.io_out_addr  = out_addr_q;
  assign bus.io_in_valid  = in_valid_q;
  assign bus.io_in_dout   = in_dout_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit)     state_nxt = READ;
      READ:    if (bus.io_out_wait_n)  state_nxt = WAIT;
      WAIT:    if (bus.io_out_valid)   state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      tag        <= '0;
      data       <= '0;
      valid      <= 1'b0;
      in_valid_q <= 1'b0;
      in_dout_q  <= '0;
      out_addr_q <= '0;
    end else begin
      in_valid_q <= 1'b0;
      if (accept) begin
        if (hit) begin
          in_valid_q <= 1'b1;
          in_dout_q  <= bus.io_in_addr[0] ? data[63:32] : data[31:0];
        end else begin
          addr_q     <= bus.io_in_addr;
          out_addr_q <= {13'h0, bus.io_in_addr[16:1], 3'h0};
        end
      end
      if (state == WAIT && bus.io_out_valid) begin
        data       <= bus.io_out_dout;
        tag        <= addr_q[16:1];
        valid      <= 1'b1;
        in_valid_q <= 1'b1;
        in_dout_q  <= addr_q[0] ? bus.io_out_dout[63:32] : bus.io_out_dout[31:0];
      end
      // Flush wins over a same-cycle fill: the word still goes out, the line stays invalid.
      if (bus.io_flush) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_read_adapter.sv
// Directed, table-driven bench for mem_read_adapter.
module tb_mem_read_adapter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   pulse_cnt = 0;

  always #5 clk = ~clk;

  mem_read_adapter_if bus();

  mem_read_adapter dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.io_in_valid === 1'b1) pulse_cnt++;

  typedef struct {
    logic [16:0] addr;
    logic        flush;
    logic        exp_hit;
    logic [31:0] exp_dout;
    logic [31:0] exp_oaddr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Memory side: wait for io_out_rd, stall, accept, then return rdata after lat cycles.
  task automatic serve(input string nm, input logic [31:0] exp_oaddr, input logic [63:0] rdata,
                       input int stall, input int lat, input logic fl_cap, input logic [31:0] exp_dout);
    int n = 0;
    while (bus.io_out_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " out_rd seen"}, {63'h0, bus.io_out_rd}, 64'h1);
    chk({nm, " out_addr"}, {32'h0, bus.io_out_addr}, {32'h0, exp_oaddr});
    for (int i = 0; i < stall; i++) begin
      bus.io_out_wait_n = 1'b0;
      #1;
      chk({nm, " stall out_rd"}, {63'h0, bus.io_out_rd}, 64'h1);
      chk({nm, " stall out_addr"}, {32'h0, bus.io_out_addr}, {32'h0, exp_oaddr});
      chk({nm, " stall in_wait_n"}, {63'h0, bus.io_in_wait_n}, 64'h0);
      tick();
    end
    bus.io_out_wait_n = 1'b1;
    tick();
    bus.io_out_wait_n = 1'b0;
    #1;
    chk({nm, " wait out_rd"}, {63'h0, bus.io_out_rd}, 64'h0);
    for (int i = 1; i < lat; i++) tick();
    bus.io_out_valid = 1'b1;
    bus.io_out_dout  = rdata;
    bus.io_flush     = fl_cap;
    tick();
    bus.io_out_valid = 1'b0;
    bus.io_out_dout  = '0;
    bus.io_flush     = 1'b0;
    chk({nm, " in_valid"}, {63'h0, bus.io_in_valid}, 64'h1);
    chk({nm, " in_dout"}, {32'h0, bus.io_in_dout}, {32'h0, exp_dout});
  endtask

  initial begin
    int p0;
    vecs[0] = '{17'h00004, 1'b0, 1'b1, 32'h33334444, 32'h0};
    vecs[1] = '{17'h00005, 1'b0, 1'b1, 32'h11112222, 32'h0};
    vecs[2] = '{17'h00005, 1'b0, 1'b1, 32'h11112222, 32'h0};
    vecs[3] = '{17'h00004, 1'b0, 1'b1, 32'h33334444, 32'h0};
    vecs[4] = '{17'h00004, 1'b1, 1'b0, 32'h0,        32'h00000010};

    rst = 1'b1;
    bus.io_enable = 1'b0;  bus.io_flush = 1'b0;  bus.io_in_rd = 1'b0;  bus.io_in_addr = '0;
    bus.io_out_wait_n = 1'b0;  bus.io_out_valid = 1'b0;  bus.io_out_dout = '0;
    repeat (3) tick();
    chk("rst in_valid", {63'h0, bus.io_in_valid}, 64'h0);
    chk("rst out_rd", {63'h0, bus.io_out_rd}, 64'h0);
    chk("rst in_dout", {32'h0, bus.io_in_dout}, 64'h0);
    chk("rst out_addr", {32'h0, bus.io_out_addr}, 64'h0);
    rst = 1'b0;

    // First miss fills the line holding words 4/5.
    p0 = pulse_cnt;
    bus.io_enable = 1'b1;  bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00005;
    #1;
    chk("first wait_n", {63'h0, bus.io_in_wait_n}, 64'h1);
    tick();
    bus.io_in_rd = 1'b0;
    serve("miss5", 32'h00000010, 64'h11112222_33334444, 0, 3, 1'b0, 32'h11112222);
    tick();
    tick();
    chk("miss5 one pulse", 64'(pulse_cnt - p0), 64'd1);
    chk("dout held", {32'h0, bus.io_in_dout}, {32'h0, 32'h11112222});

    // Back-to-back hits, ending with a flush-forced miss.
    for (int i = 0; i < 5; i++) begin
      bus.io_in_rd = 1'b1;  bus.io_in_addr = vecs[i].addr;  bus.io_flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d wait_n", i), {63'h0, bus.io_in_wait_n}, 64'h1);
      tick();
      if (vecs[i].exp_hit) begin
        chk($sformatf("v%0d in_valid", i), {63'h0, bus.io_in_valid}, 64'h1);
        chk($sformatf("v%0d in_dout", i), {32'h0, bus.io_in_dout}, {32'h0, vecs[i].exp_dout});
        chk($sformatf("v%0d no out_rd", i), {63'h0, bus.io_out_rd}, 64'h0);
      end else begin
        bus.io_in_rd = 1'b0;  bus.io_flush = 1'b0;
        chk($sformatf("v%0d miss out_rd", i), {63'h0, bus.io_out_rd}, 64'h1);
        chk($sformatf("v%0d miss in_valid", i), {63'h0, bus.io_in_valid}, 64'h0);
        chk($sformatf("v%0d out_addr", i), {32'h0, bus.io_out_addr}, {32'h0, vecs[i].exp_oaddr});
      end
    end

    // Flush miss served with a 5-cycle stall; request issued during the data pulse.
    serve("stall", 32'h00000010, 64'hAAAABBBB_CCCCDDDD, 5, 1, 1'b0, 32'hCCCCDDDD);
    bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00005;
    #1;
    chk("pulse-cycle wait_n", {63'h0, bus.io_in_wait_n}, 64'h1);
    tick();
    bus.io_in_rd = 1'b0;
    chk("pulse-cycle hit valid", {63'h0, bus.io_in_valid}, 64'h1);
    chk("pulse-cycle hit dout", {32'h0, bus.io_in_dout}, {32'h0, 32'hAAAABBBB});

    // Flush coinciding with the fill: word returned, line left invalid.
    bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00010;
    tick();
    bus.io_in_rd = 1'b0;
    serve("flushfill", 32'h00000040, 64'h55556666_77778888, 0, 2, 1'b1, 32'h77778888);
    tick();
    bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00011;
    tick();
    bus.io_in_rd = 1'b0;
    chk("after flushfill miss", {63'h0, bus.io_out_rd}, 64'h1);
    serve("refill", 32'h00000040, 64'h99990000_12345678, 0, 1, 1'b0, 32'h99990000);

    // Reset during WAIT, then a stale response.
    tick();
    p0 = pulse_cnt;
    bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00020;
    tick();
    bus.io_in_rd = 1'b0;
    bus.io_out_wait_n = 1'b1;
    tick();
    bus.io_out_wait_n = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.io_out_valid = 1'b1;  bus.io_out_dout = 64'hDEADBEEF_CAFEF00D;
    tick();
    bus.io_out_valid = 1'b0;  bus.io_out_dout = '0;
    tick();
    chk("stale no pulse", 64'(pulse_cnt - p0), 64'd0);
    chk("stale idle", {63'h0, bus.io_in_wait_n}, 64'h1);
    chk("stale dout", {32'h0, bus.io_in_dout}, 64'h0);
    bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00020;
    tick();
    bus.io_in_rd = 1'b0;
    chk("post-reset miss", {63'h0, bus.io_out_rd}, 64'h1);
    serve("post-reset", 32'h00000080, 64'h0BAD0BAD_600DF00D, 0, 1, 1'b0, 32'h600DF00D);
    tick();

    // Enable low blocks acceptance; dropping it mid-transaction does not abort.
    bus.io_enable = 1'b0;  bus.io_in_rd = 1'b1;  bus.io_in_addr = 17'h00031;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("dis%0d wait_n", i), {63'h0, bus.io_in_wait_n}, 64'h0);
      chk($sformatf("dis%0d out_rd", i), {63'h0, bus.io_out_rd}, 64'h0);
      tick();
    end
    bus.io_enable = 1'b1;
    #1;
    chk("enable wait_n", {63'h0, bus.io_in_wait_n}, 64'h1);
    tick();
    bus.io_in_rd = 1'b0;  bus.io_enable = 1'b0;
    chk("enable accepted", {63'h0, bus.io_out_rd}, 64'h1);
    serve("disabled-inflight", 32'h000000C0, 64'h0F0F0F0F_F0F0F0F0, 2, 2, 1'b0, 32'h0F0F0F0F);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_read_adapter.md
MEM_READ_ADAPTER -- requirements
Module: mem_read_adapter

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port io_enable, input, 1 bit: permits acceptance of new requests.
REQ-004 The block SHALL have the port io_flush, input, 1 bit: invalidates the cached line.
REQ-005 The block SHALL have the port io_in_rd, input, 1 bit: client read request.
REQ-006 The block SHALL have the port io_in_addr, input, 17 bits: client 32-bit word address.
REQ-007 The block SHALL have the port io_in_wait_n, output, 1 bit: high when a request is accepted this cycle.
REQ-008 The block SHALL have the port io_in_valid, output, 1 bit: one-cycle pulse marking io_in_dout valid.
REQ-009 The block SHALL have the port io_in_dout, output, 32 bits: returned word.
REQ-010 The block SHALL have the port io_out_rd, output, 1 bit: memory read request.
REQ-011 The block SHALL have the port io_out_addr, output, 32 bits: memory byte address, 64-bit aligned.
REQ-012 The block SHALL have the port io_out_wait_n, input, 1 bit: memory accepts io_out_rd this cycle.
REQ-013 The block SHALL have the port io_out_valid, input, 1 bit: memory read data valid.
REQ-014 The block SHALL have the port io_out_dout, input, 64 bits: memory read data.

Function
REQ-015 The block SHALL implement states IDLE, READ and WAIT, encoded in one state register.
REQ-016 The block SHALL drive io_in_wait_n = io_enable AND (state == IDLE); a request is accepted when io_in_rd AND io_in_wait_n are both high.
REQ-017 The block SHALL keep a one-line cache: a 64-bit data register, a 16-bit tag, and a valid bit.
REQ-018 On an accepted request, a hit SHALL be tag == io_in_addr[16:1] AND valid AND NOT io_flush; io_flush takes priority and forces a miss.
REQ-019 On an accepted hit, the block SHALL remain in IDLE and, on the next cycle, pulse io_in_valid with io_in_dout = io_in_addr[0] ? data[63:32] : data[31:0], using the address latched at acceptance.
REQ-020 Back-to-back hits SHALL be sustainable at one request per cycle.
REQ-021 On an accepted miss, the block SHALL latch io_in_addr and enter READ on the next cycle.
REQ-022 In READ, the block SHALL hold io_out_rd = 1 and io_out_addr = {13'h0, latched_addr[16:1], 3'h0} until io_out_wait_n is sampled high, then enter WAIT.
REQ-023 io_out_rd SHALL be 0 in every state other than READ.
REQ-024 In WAIT, on io_out_valid the block SHALL capture io_out_dout into the cache data, set tag = latched_addr[16:1], set valid, and return to IDLE.
REQ-025 On the cycle after that capture, the block SHALL pulse io_in_valid with the half selected by latched_addr[0].
REQ-026 A new request SHALL be acceptable in the same cycle as that io_in_valid pulse.
REQ-027 The block SHALL ignore io_out_valid in IDLE and READ.
REQ-028 io_flush SHALL clear the cache valid bit on the next cycle in any state.
REQ-029 If io_flush coincides with the io_out_valid capture in WAIT, the block SHALL still return the captured word to the client but leave the cache valid bit 0.
REQ-030 Deasserting io_enable SHALL block new acceptances only; an in-flight READ/WAIT transaction SHALL complete normally.
REQ-031 io_in_dout SHALL hold its last value between io_in_valid pulses.

Reset
REQ-032 On reset, the block SHALL set state = IDLE, cache valid = 0, io_in_valid = 0, io_out_rd = 0, and io_in_dout, io_out_addr, tag and data = 0.
REQ-033 A reset asserted during READ or WAIT SHALL abandon the transaction without producing an io_in_valid pulse.
REQ-034 A memory response arriving after a mid-transaction reset SHALL be ignored.

Verification
REQ-035 Scenario: after reset, read addr 0x00005 with memory returning 0x11112222_33334444 after 3 cycles -> io_out_addr = 0x00000010, exactly one io_in_valid pulse, io_in_dout = 0x11112222.
REQ-036 Scenario: immediately afterwards, read addr 0x00004 -> no io_out_rd, io_in_valid on the cycle after acceptance, io_in_dout = 0x33334444.
REQ-037 Scenario: assert io_flush together with a read of addr 0x00004 -> treated as a miss, io_out_rd asserted with io_out_addr = 0x00000010.
REQ-038 Scenario: hold io_out_wait_n low for 5 cycles in READ -> io_out_rd and io_out_addr are stable for all 5 cycles, and io_in_wait_n = 0 throughout.
REQ-039 Scenario: assert reset during WAIT, then pulse io_out_valid -> no io_in_valid pulse, state = IDLE, and the next read of the same line misses.
REQ-040 Scenario: hold io_enable = 0 with io_in_rd = 1 -> io_in_wait_n = 0 and no memory traffic; raising io_enable causes acceptance in that cycle.
